// File: rtl/rk05_bus_input_conditioner_pkg.sv
// rk05_bus_input_conditioner_pkg: shared defaults for the RK05 bus input front end.
package rk05_bus_input_conditioner_pkg;
  localparam int RK05_WIDTH = 4;
  localparam int RK05_SYNC_STAGES = 2;
  localparam int RK05_FILTER_CYCLES = 8;
  localparam logic RK05_INACTIVE = 1'b1;
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction
endpackage

// File: rtl/rk05_bus_input_conditioner_sync_filter.sv
// rk05_bus_input_conditioner_sync_filter: one channel of set-type synchronizer plus stability filter.
module rk05_dff_set
  import rk05_bus_input_conditioner_pkg::*;
(
  input  logic clock,
  input  logic set,
  input  logic d,
  output logic q
);
  always_ff @(posedge clock or posedge set)
    if (set) q <= RK05_INACTIVE;
    else q <= d;
endmodule

module rk05_bus_input_conditioner_sync_filter
  import rk05_bus_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = RK05_SYNC_STAGES,
  parameter int FILTER_CYCLES = RK05_FILTER_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic bus_n_in,
  input  logic glitch_clr,
  output logic level_n_out,
  output logic assert_pulse,
  output logic release_pulse,
  output logic glitch_flag
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  logic [SYNC_STAGES:0] sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, ap_q, ap_d, rp_q, rp_d, glitch_q, glitch_d;
  logic s, diff, fire;
  assign sync[0] = bus_n_in;
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    rk05_dff_set u_ff (.clock(clock), .set(reset), .d(sync[i]), .q(sync[i+1]));
  end
  assign s = sync[SYNC_STAGES];
  always_comb begin
    diff = s != level_q;
    fire = diff && cnt_q == CW'(FILTER_CYCLES - 1);
    cnt_d = (!diff || fire) ? '0 : cnt_q + 1'b1;
    level_d = fire ? s : level_q;
    ap_d = fire && !s;
    rp_d = fire && s;
    // an abandoned partial count means the input bounced back before being accepted
    glitch_d = (!diff && cnt_q != '0) || (glitch_q && !glitch_clr);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      level_q <= RK05_INACTIVE;
      ap_q <= 1'b0;
      rp_q <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
      ap_q <= ap_d;
      rp_q <= rp_d;
      glitch_q <= glitch_d;
    end
  assign level_n_out = level_q;
  assign assert_pulse = ap_q;
  assign release_pulse = rp_q;
  assign glitch_flag = glitch_q;
endmodule

// File: rtl/rk05_bus_input_conditioner.sv
// rk05_bus_input_conditioner: WIDTH independent synchronize-and-filter channels for active-low RK05 controls.
module rk05_bus_input_conditioner
  import rk05_bus_input_conditioner_pkg::*;
#(
  parameter int WIDTH = RK05_WIDTH,
  parameter int SYNC_STAGES = RK05_SYNC_STAGES,
  parameter int FILTER_CYCLES = RK05_FILTER_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_n_in,
  output logic [WIDTH-1:0] level_n_out,
  output logic [WIDTH-1:0] assert_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] glitch_flag,
  input  logic [WIDTH-1:0] glitch_clr
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    rk05_bus_input_conditioner_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .bus_n_in(bus_n_in[i]),
      .glitch_clr(glitch_clr[i]),
      .level_n_out(level_n_out[i]),
      .assert_pulse(assert_pulse[i]),
      .release_pulse(release_pulse[i]),
      .glitch_flag(glitch_flag[i])
    );
  end
endmodule
